// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the picosoc iomem bus with registered slave outputs
// and a watchdog that completes hung slave transactions with an error word.
module iomem_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk25,
    input  logic        resetn,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        s_grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_last;
    logic [15:0] r_cnt;
    logic        r_m0_ready, r_m1_ready, r_s_valid, r_s_grant, r_timeout_err;
    logic [31:0] r_m0_rdata, r_m1_rdata, r_s_addr, r_s_wdata;
    logic [3:0]  r_s_wstrb;

    logic w_any;
    logic w_pick1;

    assign w_any   = m0_valid | m1_valid;
    // m1 wins when alone, or on a tie when m0 was served last
    assign w_pick1 = m1_valid & (~m0_valid | ~r_last);

    always_ff @(posedge clk25) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_last        <= 1'b1;
            r_cnt         <= '0;
            r_m0_ready    <= 1'b0;
            r_m1_ready    <= 1'b0;
            r_m0_rdata    <= '0;
            r_m1_rdata    <= '0;
            r_s_valid     <= 1'b0;
            r_s_wstrb     <= '0;
            r_s_addr      <= '0;
            r_s_wdata     <= '0;
            r_s_grant     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_m0_ready    <= 1'b0;
            r_m1_ready    <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_s_grant <= w_pick1;
                        r_last    <= w_pick1;
                        r_s_addr  <= w_pick1 ? m1_addr  : m0_addr;
                        r_s_wdata <= w_pick1 ? m1_wdata : m0_wdata;
                        r_s_wstrb <= w_pick1 ? m1_wstrb : m0_wstrb;
                        r_s_valid <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        r_s_valid <= 1'b0;
                        if (r_s_grant) begin
                            r_m1_rdata <= s_rdata;
                            r_m1_ready <= 1'b1;
                        end else begin
                            r_m0_rdata <= s_rdata;
                            r_m0_ready <= 1'b1;
                        end
                        r_state <= DONE;
                    end else if (r_cnt == CNT_MAX) begin
                        r_s_valid     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        if (r_s_grant) begin
                            r_m1_rdata <= ERR_DATA;
                            r_m1_ready <= 1'b1;
                        end else begin
                            r_m0_rdata <= ERR_DATA;
                            r_m0_ready <= 1'b1;
                        end
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                // Requester's valid is still high here for the finished request
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m0_ready    = r_m0_ready;
    assign m1_ready    = r_m1_ready;
    assign m0_rdata    = r_m0_rdata;
    assign m1_rdata    = r_m1_rdata;
    assign s_valid     = r_s_valid;
    assign s_wstrb     = r_s_wstrb;
    assign s_addr      = r_s_addr;
    assign s_wdata     = r_s_wdata;
    assign s_grant     = r_s_grant;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter built with an 8-cycle watchdog.
module tb_iomem_arbiter;

    logic        clk25 = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid, s_ready;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
    logic        m0_ready, m1_ready, s_valid, s_grant, timeout_err;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    iomem_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk25(clk25), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_grant(s_grant), .timeout_err(timeout_err)
    );

    always #5 clk25 = ~clk25;

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        m0_wstrb = 0; m1_wstrb = 0; m0_addr = 0; m1_addr = 0;
        m0_wdata = 0; m1_wdata = 0; s_rdata = 0;
        tick(); tick();
        n_cmp++;
        if ({s_valid, m0_ready, m1_ready, s_grant, timeout_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {s_valid, m0_ready, m1_ready, s_grant, timeout_err});
        end
        n_cmp++;
        if ({s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata} !== 132'b0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0", {s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata});
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        m0_valid = 1; m0_addr = 32'h0300_0000; m0_wstrb = 4'b0000;
        tick();
        n_cmp++;
        if ({s_valid, s_grant, m0_ready} !== 3'b100 || s_addr !== 32'h0300_0000 || s_wstrb !== 4'b0) begin
            n_bad++; $display("FAIL read_c1: got v/g/r=%b addr=%h wstrb=%b want 100 03000000 0000", {s_valid, s_grant, m0_ready}, s_addr, s_wstrb);
        end
        tick();
        n_cmp++;
        if (s_valid !== 1'b1 || m0_ready !== 1'b0) begin
            n_bad++; $display("FAIL read_c2: got s_valid=%b m0_ready=%b want 1 0", s_valid, m0_ready);
        end
        s_ready = 1; s_rdata = 32'h0000_00A5;
        tick();
        s_ready = 0; s_rdata = 0; m0_valid = 0;
        n_cmp++;
        if ({s_valid, m0_ready, m1_ready} !== 3'b010 || m0_rdata !== 32'h0000_00A5) begin
            n_bad++; $display("FAIL read_c3: got v/r0/r1=%b rdata=%h want 010 000000a5", {s_valid, m0_ready, m1_ready}, m0_rdata);
        end
        tick();
        n_cmp++;
        if ({s_valid, m0_ready, m1_ready} !== 3'b000 || m0_rdata !== 32'h0000_00A5) begin
            n_bad++; $display("FAIL read_c4: got v/r0/r1=%b rdata=%h want 000 000000a5", {s_valid, m0_ready, m1_ready}, m0_rdata);
        end
    endtask

    task automatic test_single_write();
        m1_valid = 1; m1_addr = 32'h0300_0004; m1_wstrb = 4'b0001; m1_wdata = 32'h55;
        tick();
        n_cmp++;
        if (s_valid !== 1'b1 || s_grant !== 1'b1 || s_wstrb !== 4'b0001 || s_wdata !== 32'h55 || s_addr !== 32'h0300_0004) begin
            n_bad++; $display("FAIL write_fwd: got v=%b g=%b wstrb=%b wdata=%h addr=%h want 1 1 0001 00000055 03000004", s_valid, s_grant, s_wstrb, s_wdata, s_addr);
        end
        s_ready = 1; s_rdata = 32'h1234_5678;
        tick();
        s_ready = 0; s_rdata = 0; m1_valid = 0;
        n_cmp++;
        if ({m1_ready, m0_ready, s_valid} !== 3'b100 || m1_rdata !== 32'h1234_5678 || m0_rdata !== 32'h0000_00A5) begin
            n_bad++; $display("FAIL write_done: got r1/r0/v=%b m1_rdata=%h m0_rdata=%h want 100 12345678 000000a5", {m1_ready, m0_ready, s_valid}, m1_rdata, m0_rdata);
        end
        tick();
        n_cmp++;
        if (m1_ready !== 1'b0 || s_grant !== 1'b1) begin
            n_bad++; $display("FAIL write_after: got m1_ready=%b s_grant=%b want 0 1", m1_ready, s_grant);
        end
    endtask

    task automatic test_contention();
        logic        g;
        logic [31:0] rd;
        m0_valid = 1; m0_addr = 32'h0300_0010; m0_wstrb = 0;
        m1_valid = 1; m1_addr = 32'h0300_0020; m1_wstrb = 0;
        for (int i = 0; i < 4; i++) begin
            g = (i % 2 == 1);
            tick();
            n_cmp++;
            if (s_valid !== 1'b1 || s_grant !== g || s_addr !== (g ? 32'h0300_0020 : 32'h0300_0010)) begin
                n_bad++; $display("FAIL cont_grant%0d: got v=%b g=%b addr=%h want 1 %b", i, s_valid, s_grant, s_addr, g);
            end
            s_ready = 1; s_rdata = 32'h100 + i;
            tick();
            s_ready = 0;
            rd = g ? m1_rdata : m0_rdata;
            n_cmp++;
            if (s_valid !== 1'b0 || m0_ready !== !g || m1_ready !== g || rd !== 32'h100 + i) begin
                n_bad++; $display("FAIL cont_done%0d: got v=%b r0=%b r1=%b rdata=%h want 0 %b %b %h", i, s_valid, m0_ready, m1_ready, rd, !g, g, 32'h100 + i);
            end
            if (i == 3) begin
                m0_valid = 0; m1_valid = 0;
            end
            tick();
            n_cmp++;
            if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
                n_bad++; $display("FAIL cont_gap%0d: got v=%b r0=%b r1=%b want 0 0 0", i, s_valid, m0_ready, m1_ready);
            end
        end
    endtask

    task automatic test_timeout();
        m0_valid = 1; m0_addr = 32'h0300_0040; m0_wstrb = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_cmp++;
            if (s_valid !== 1'b1 || m0_ready !== 1'b0 || timeout_err !== 1'b0) begin
                n_bad++; $display("FAIL to_hold%0d: got v=%b r0=%b err=%b want 1 0 0", c, s_valid, m0_ready, timeout_err);
            end
        end
        tick();
        m0_valid = 0;
        n_cmp++;
        if (s_valid !== 1'b0 || m0_ready !== 1'b1 || timeout_err !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m1_ready !== 1'b0) begin
            n_bad++; $display("FAIL to_abort: got v=%b r0=%b err=%b rdata=%h r1=%b want 0 1 1 deadbeef 0", s_valid, m0_ready, timeout_err, m0_rdata, m1_ready);
        end
        tick();
        n_cmp++;
        if (m0_ready !== 1'b0 || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL to_pulse: got r0=%b err=%b want 0 0", m0_ready, timeout_err);
        end
        tick();
        s_ready = 1; s_rdata = 32'h77;
        tick();
        s_ready = 0; s_rdata = 0;
        tick();
        n_cmp++;
        if ({s_valid, m0_ready, m1_ready, timeout_err} !== 4'b0 || m0_rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL to_late: got v/r0/r1/err=%b rdata=%h want 0000 deadbeef", {s_valid, m0_ready, m1_ready, timeout_err}, m0_rdata);
        end
    endtask

    task automatic test_drop_valid();
        m1_valid = 1; m1_addr = 32'h0300_0080; m1_wstrb = 4'b1111; m1_wdata = 32'hCAFE_0001;
        tick();
        m1_valid = 0;
        tick();
        n_cmp++;
        if (s_valid !== 1'b1 || s_wstrb !== 4'b1111 || s_wdata !== 32'hCAFE_0001) begin
            n_bad++; $display("FAIL drop_hold: got v=%b wstrb=%b wdata=%h want 1 1111 cafe0001", s_valid, s_wstrb, s_wdata);
        end
        s_ready = 1; s_rdata = 32'h9;
        tick();
        s_ready = 0;
        n_cmp++;
        if (m1_ready !== 1'b1 || m1_rdata !== 32'h9) begin
            n_bad++; $display("FAIL drop_ready: got r1=%b rdata=%h want 1 00000009", m1_ready, m1_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        m0_valid = 1; m0_addr = 32'h0300_00C0; m0_wstrb = 4'b0011; m0_wdata = 32'h0BAD;
        tick(); tick();
        n_cmp++;
        if (s_valid !== 1'b1 || s_grant !== 1'b0) begin
            n_bad++; $display("FAIL mid_busy: got v=%b g=%b want 1 0", s_valid, s_grant);
        end
        resetn = 0;
        tick();
        n_cmp++;
        if ({s_valid, m0_ready, m1_ready, s_grant, timeout_err} !== 5'b0 || s_addr !== 0 || s_wstrb !== 0 || m0_rdata !== 0) begin
            n_bad++; $display("FAIL mid_reset: got ctrl=%b addr=%h wstrb=%b m0_rdata=%h want 00000 0 0 0", {s_valid, m0_ready, m1_ready, s_grant, timeout_err}, s_addr, s_wstrb, m0_rdata);
        end
        m0_valid = 0;
        tick();
        resetn = 1;
        tick();
        n_cmp++;
        if ({s_valid, m0_ready} !== 2'b00) begin
            n_bad++; $display("FAIL mid_noready: got v/r0=%b want 00", {s_valid, m0_ready});
        end
        m0_valid = 1; m1_valid = 1; m0_addr = 32'h0300_00D0; m1_addr = 32'h0300_00E0;
        tick();
        n_cmp++;
        if (s_valid !== 1'b1 || s_grant !== 1'b0 || s_addr !== 32'h0300_00D0) begin
            n_bad++; $display("FAIL mid_first: got v=%b g=%b addr=%h want 1 0 030000d0", s_valid, s_grant, s_addr);
        end
        s_ready = 1;
        tick();
        s_ready = 0; m0_valid = 0; m1_valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_timeout();
        test_drop_valid();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter.md
Name: iomem_arbiter

Overview:
- Two-master, one-slave arbiter for the picosoc iomem bus (valid/ready, wstrb, 32-bit addr/wdata/rdata).
- Shares the slave-side peripheral bus (GPIO and future iomem peripherals) between the CPU (m0) and a second requester such as a debug/DMA bridge (m1).
- Round-robin grant, registered slave-side outputs, and a bus watchdog that completes hung transactions with an error word.
- Sits between the picosoc iomem port / second master and the iomem address decoder, in the clk25 domain.

Parameters:
- TIMEOUT, 255: maximum cycles s_valid is held without s_ready before abort; range 1..65535.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned to the master on timeout.

Ports:
- clk25  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- m0_valid  in  1  master 0 request.
- m0_ready  out  1  master 0 completion pulse.
- m0_wstrb  in  4  master 0 byte write strobes; 0 means read.
- m0_addr  in  32  master 0 address.
- m0_wdata  in  32  master 0 write data.
- m0_rdata  out  32  master 0 read data, valid while m0_ready=1.
- m1_valid, m1_ready, m1_wstrb, m1_addr, m1_wdata, m1_rdata: same directions, widths and meanings for master 1.
- s_valid  out  1  slave request.
- s_ready  in  1  slave completion.
- s_wstrb  out  4  forwarded strobes.
- s_addr  out  32  forwarded address.
- s_wdata  out  32  forwarded write data.
- s_rdata  in  32  slave read data, sampled when s_ready=1.
- s_grant  out  1  index of the master owning the current or last transaction.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values, applied on any clk25 edge with resetn=0, including mid-transaction:
  - all outputs 0;
  - state IDLE; timeout counter 0;
  - round-robin pointer last=1, so m0 wins the first tie.
  - An in-flight transaction is abandoned; no ready pulse is issued.
- The state machine has three states: IDLE, BUSY and DONE.
- IDLE:
  - If only one mX_valid is high, grant that master.
  - If both are high, grant the master != last.
  - On grant, register mX_addr/wdata/wstrb into s_addr/s_wdata/s_wstrb, set s_grant, set last to the granted index, set s_valid=1, clear the counter, and go to BUSY.
  - If no valid is high, stay in IDLE.
- BUSY:
  - s_valid stays 1; s_addr/s_wdata/s_wstrb are held stable.
  - If s_ready=1:
    - s_valid goes to 0 next cycle;
    - the granted mX_rdata is loaded with s_rdata;
    - the granted mX_ready=1 for exactly one cycle;
    - go to DONE.
  - Else if counter == TIMEOUT-1:
    - s_valid goes to 0;
    - mX_rdata is loaded with ERR_DATA;
    - mX_ready=1 and timeout_err=1, each for one cycle;
    - go to DONE.
  - Else the counter increments.
- DONE:
  - Lasts exactly one cycle, during which the master observes ready.
  - No new grant is made in DONE, because the master's valid is still asserted for the completed request.
  - Go to IDLE.
- The non-granted master's ready is always 0; its rdata holds its previous value.
- The granted master's rdata holds until its next completion.
- Latency, m_valid rising in IDLE at cycle 0:
  - s_valid=1 at cycle 1.
  - With s_ready at cycle k (k>=1), m_ready=1 at cycle k+1.
  - Minimum is 2 cycles with a combinational slave, 3 with a registered-ready slave.
- Re-issue: a master holding valid in the cycle after DONE is treated as a new request. Back-to-back requests from both masters alternate m0, m1, m0, ...
- A late s_ready after a timeout abort is ignored; s_valid is already 0.
- If a master drops valid while BUSY (protocol violation), the slave transaction still completes and the ready pulse is still issued.
- wstrb is forwarded unmodified. The arbiter does no address decode.

Test Plan:
- Single read: m0_valid, addr=0x0300_0000, wstrb=0; slave returns s_ready at cycle 2 with rdata=0x0000_00A5 -> s_valid at cycle 1 only through cycle 2, m0_ready=1 at cycle 3 with m0_rdata=0xA5, m1_ready stays 0.
- Single write: m1_valid, wstrb=4'b0001, wdata=0x55 -> s_wstrb=1, s_wdata=0x55, s_grant=1 while s_valid; m1_ready one cycle after s_ready.
- Contention: both valid continuously for 4 transactions with a 1-cycle-ready slave -> grant order m0, m1, m0, m1; never two s_valid-high transactions overlapping; a DONE gap between each.
- Timeout with TIMEOUT=8 and s_ready tied 0 -> s_valid high for exactly 8 cycles, then m0_ready=1, m0_rdata=0xDEADBEEF, timeout_err=1 for one cycle; an s_ready pulse 2 cycles later produces no response.
- Reset mid-op: assert resetn=0 while BUSY -> next edge s_valid=0, all readies 0, s_grant=0; after release a simultaneous m0/m1 request grants m0 first.
